// File: rtl/apb_uart_regs.sv
// APB register block for a UART: TX/RX FIFO access, baud divisor, interrupt enables and
// sticky error flags. RXDATA reads insert one wait state while the RX FIFO is popped.
module apb_uart_regs #(
  parameter logic [10:0] BAUD_RESET = 11'd650
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [10:0] baud_final_value,
  output logic [7:0]  tx_fifo_dataIn,
  output logic        tx_fifo_writeEn,
  input  logic        tx_fifo_Full,
  output logic        rx_fifo_readEn,
  input  logic        rx_fifo_Empty,
  input  logic [7:0]  rx_fifo_dataOut,
  output logic        irq
);

  localparam logic [5:0] A_TXDATA = 6'd0;
  localparam logic [5:0] A_RXDATA = 6'd1;
  localparam logic [5:0] A_STATUS = 6'd2;
  localparam logic [5:0] A_BAUD   = 6'd3;
  localparam logic [5:0] A_IER    = 6'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [10:0] baud_r;
  logic [1:0]  ier_r;
  logic        tx_ovf_r;
  logic        rx_udf_r;
  logic        tx_we_r;
  logic [7:0]  tx_data_r;
  logic        irq_r;

  logic [5:0]  word_s;
  logic        setup_s;
  logic        access_s;
  logic [31:0] prdata_s;
  logic        pslverr_s;
  logic        push_s;
  logic        tx_ovf_set_s;
  logic        rx_udf_set_s;
  logic        tx_ovf_clr_s;
  logic        rx_udf_clr_s;
  logic        baud_we_s;
  logic        ier_we_s;
  logic        unused_s;

  assign word_s   = PADDR[7:2];
  assign setup_s  = PSEL & ~PENABLE;
  // Zero-wait accesses are only decoded in IDLE; the RXDATA pop path owns POP/DONE.
  assign access_s = PSEL & PENABLE & ~reset & (state_r == ST_IDLE);
  assign unused_s = &{1'b0, PADDR[1:0], PWDATA[31:11]};

  // Next-state logic: only a setup-phase RXDATA read with data available leaves IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (setup_s && !PWRITE && (word_s == A_RXDATA) && !rx_fifo_Empty) begin
          state_nxt_s = ST_POP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_POP:  state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Register decode: read mux, error response and write/flag side effects.
  always_comb begin
    prdata_s     = 32'd0;
    pslverr_s    = 1'b0;
    push_s       = 1'b0;
    tx_ovf_set_s = 1'b0;
    rx_udf_set_s = 1'b0;
    tx_ovf_clr_s = 1'b0;
    rx_udf_clr_s = 1'b0;
    baud_we_s    = 1'b0;
    ier_we_s     = 1'b0;
    if (access_s && PWRITE) begin
      case (word_s)
        A_TXDATA: begin
          if (tx_fifo_Full) begin
            pslverr_s    = 1'b1;
            tx_ovf_set_s = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end
        A_STATUS: begin
          tx_ovf_clr_s = PWDATA[2];
          rx_udf_clr_s = PWDATA[3];
        end
        A_BAUD:  baud_we_s = 1'b1;
        A_IER:   ier_we_s  = 1'b1;
        default: pslverr_s = 1'b1;
      endcase
    end else if (access_s) begin
      case (word_s)
        A_TXDATA: prdata_s = 32'd0;
        A_RXDATA: begin
          // Reaching here in IDLE means the FIFO was empty at setup: underflow.
          pslverr_s    = 1'b1;
          rx_udf_set_s = 1'b1;
        end
        A_STATUS: prdata_s = {28'd0, rx_udf_r, tx_ovf_r, rx_fifo_Empty, tx_fifo_Full};
        A_BAUD:   prdata_s = {21'd0, baud_r};
        A_IER:    prdata_s = {30'd0, ier_r};
        default:  pslverr_s = 1'b1;
      endcase
    end else if ((state_r == ST_DONE) && PSEL && PENABLE) begin
      prdata_s = {24'd0, rx_fifo_dataOut};
    end else begin
      prdata_s = 32'd0;
    end
  end

  // State, configuration, sticky flags, push strobe and interrupt registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      baud_r    <= BAUD_RESET;
      ier_r     <= 2'd0;
      tx_ovf_r  <= 1'b0;
      rx_udf_r  <= 1'b0;
      tx_we_r   <= 1'b0;
      tx_data_r <= 8'd0;
      irq_r     <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      tx_we_r  <= push_s;
      tx_ovf_r <= tx_ovf_set_s | (tx_ovf_r & ~tx_ovf_clr_s);
      rx_udf_r <= rx_udf_set_s | (rx_udf_r & ~rx_udf_clr_s);
      irq_r    <= (ier_r[0] & ~rx_fifo_Empty) | (ier_r[1] & ~tx_fifo_Full) | tx_ovf_r | rx_udf_r;
      if (push_s) begin
        tx_data_r <= PWDATA[7:0];
      end else begin
        tx_data_r <= tx_data_r;
      end
      if (baud_we_s) begin
        baud_r <= PWDATA[10:0];
      end else begin
        baud_r <= baud_r;
      end
      if (ier_we_s) begin
        ier_r <= PWDATA[1:0];
      end else begin
        ier_r <= ier_r;
      end
    end
  end

  assign PRDATA           = prdata_s;
  assign PSLVERR          = pslverr_s;
  assign PREADY           = (state_r != ST_POP);
  assign rx_fifo_readEn   = (state_r == ST_POP);
  assign tx_fifo_writeEn  = tx_we_r;
  assign tx_fifo_dataIn   = tx_data_r;
  assign baud_final_value = baud_r;
  assign irq              = irq_r;

endmodule

// File: tb/tb_apb_uart_regs.sv
// Self-checking bench for apb_uart_regs: directed scenarios followed by random APB traffic
// compared against a register-level reference model.
module tb_apb_uart_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [10:0] baud_final_value;
  logic [7:0]  tx_fifo_dataIn;
  logic        tx_fifo_writeEn;
  logic        tx_fifo_Full;
  logic        rx_fifo_readEn;
  logic        rx_fifo_Empty;
  logic [7:0]  rx_fifo_dataOut = 8'h00;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;
  logic b2b_err = 1'b0;
  logic prev_we = 1'b0;
  logic prev_re = 1'b0;
  logic [7:0] rx_next_byte;

  // reference model state
  logic [10:0] m_baud;
  logic [1:0]  m_ier;
  logic        m_tx_ovf, m_rx_udf;
  logic [7:0]  m_tx_data;

  logic [31:0] rd;
  logic        er;
  int          pop_snap;

  apb_uart_regs dut (
    .clk(clk), .reset(reset),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR),
    .baud_final_value(baud_final_value),
    .tx_fifo_dataIn(tx_fifo_dataIn), .tx_fifo_writeEn(tx_fifo_writeEn),
    .tx_fifo_Full(tx_fifo_Full),
    .rx_fifo_readEn(rx_fifo_readEn), .rx_fifo_Empty(rx_fifo_Empty),
    .rx_fifo_dataOut(rx_fifo_dataOut),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // FIFO-side observer: counts strobes, serves RX bytes, flags back-to-back strobes.
  always @(posedge clk) begin
    prev_we <= tx_fifo_writeEn;
    prev_re <= rx_fifo_readEn;
    if ((tx_fifo_writeEn && prev_we) || (rx_fifo_readEn && prev_re)) b2b_err <= 1'b1;
    if (tx_fifo_writeEn) push_cnt <= push_cnt + 1;
    if (rx_fifo_readEn) begin
      pop_cnt         <= pop_cnt + 1;
      rx_fifo_dataOut <= rx_next_byte;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_baud    = 11'd650;
    m_ier     = 2'd0;
    m_tx_ovf  = 1'b0;
    m_rx_udf  = 1'b0;
    m_tx_data = 8'h00;
  endtask

  function automatic logic model_irq();
    return (m_ier[0] & ~rx_fifo_Empty) | (m_ier[1] & ~tx_fifo_Full) | m_tx_ovf | m_rx_udf;
  endfunction

  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int waits);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge clk);
    PENABLE = 1'b1;
    waits = 0;
    #1;
    while (PREADY !== 1'b1 && waits < 8) begin
      @(negedge clk);
      #1;
      waits++;
    end
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge clk);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // One APB transfer checked against the model, then the model is advanced.
  task automatic ref_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    int waits, exp_waits, exp_push, exp_pop, push0, pop0;
    logic [31:0] exp_rdata;
    logic exp_err;
    logic [5:0] w;
    w = addr[7:2];
    exp_rdata = 32'd0; exp_err = 1'b0; exp_waits = 0; exp_push = 0; exp_pop = 0;
    push0 = push_cnt; pop0 = pop_cnt;
    if (wr) begin
      if (w == 6'd0) begin
        if (tx_fifo_Full) exp_err = 1'b1;
        else exp_push = 1;
      end else if (w == 6'd1 || w > 6'd4) begin
        exp_err = 1'b1;
      end
    end else begin
      case (w)
        6'd0: exp_rdata = 32'd0;
        6'd1: begin
          if (rx_fifo_Empty) exp_err = 1'b1;
          else begin exp_waits = 1; exp_pop = 1; exp_rdata = {24'd0, rx_next_byte}; end
        end
        6'd2: exp_rdata = {28'd0, m_rx_udf, m_tx_ovf, rx_fifo_Empty, tx_fifo_Full};
        6'd3: exp_rdata = {21'd0, m_baud};
        6'd4: exp_rdata = {30'd0, m_ier};
        default: exp_err = 1'b1;
      endcase
    end
    apb_xfer(wr, addr, wdata, rdata, err, waits);
    check("waits", waits, exp_waits);
    check("pslverr", {31'd0, err}, {31'd0, exp_err});
    if (!wr) check("prdata", rdata, exp_rdata);
    // model update
    if (wr && w == 6'd0 && tx_fifo_Full) m_tx_ovf = 1'b1;
    if (exp_push == 1) m_tx_data = wdata[7:0];
    if (wr && w == 6'd2) begin
      if (wdata[2]) m_tx_ovf = 1'b0;
      if (wdata[3]) m_rx_udf = 1'b0;
    end
    if (wr && w == 6'd3) m_baud = wdata[10:0];
    if (wr && w == 6'd4) m_ier = wdata[1:0];
    if (!wr && w == 6'd1 && rx_fifo_Empty) m_rx_udf = 1'b1;
    repeat (3) @(negedge clk);
    check("push_count", push_cnt - push0, exp_push);
    check("pop_count", pop_cnt - pop0, exp_pop);
    check("tx_data", {24'd0, tx_fifo_dataIn}, {24'd0, m_tx_data});
    check("baud_out", {21'd0, baud_final_value}, {21'd0, m_baud});
    check("irq", {31'd0, irq}, {31'd0, model_irq()});
  endtask

  initial begin
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00; PWDATA = 32'd0;
    tx_fifo_Full = 1'b0; rx_fifo_Empty = 1'b1; rx_next_byte = 8'h00;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pready", {31'd0, PREADY}, 32'd1);
    check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_we", {31'd0, tx_fifo_writeEn}, 32'd0);
    check("rst_re", {31'd0, rx_fifo_readEn}, 32'd0);
    check("rst_txdata", {24'd0, tx_fifo_dataIn}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_baud", {21'd0, baud_final_value}, 32'd650);
    reset = 1'b0;

    // baud register reset value
    ref_xfer(1'b0, 8'h0C, 32'd0, rd, er);
    check("baud_read", rd, 32'd650);

    // TX push and overflow
    rx_fifo_Empty = 1'b0;
    ref_xfer(1'b1, 8'h00, 32'h0000_005A, rd, er);
    check("tx_push_data", {24'd0, tx_fifo_dataIn}, 32'h5A);
    tx_fifo_Full = 1'b1;
    ref_xfer(1'b1, 8'h00, 32'h0000_005A, rd, er);
    check("tx_ovf_err", {31'd0, er}, 32'd1);
    ref_xfer(1'b0, 8'h08, 32'd0, rd, er);
    check("status_ovf", rd, 32'h5);
    tx_fifo_Full = 1'b0;
    ref_xfer(1'b1, 8'h08, 32'h4, rd, er);

    // RX pop with one wait state
    rx_next_byte = 8'hC3;
    ref_xfer(1'b0, 8'h04, 32'd0, rd, er);
    check("rx_data", rd, 32'hC3);

    // RX underflow and W1C clear
    rx_fifo_Empty = 1'b1;
    ref_xfer(1'b0, 8'h04, 32'd0, rd, er);
    check("rx_udf_err", {31'd0, er}, 32'd1);
    check("rx_udf_data", rd, 32'd0);
    ref_xfer(1'b0, 8'h08, 32'd0, rd, er);
    check("status_udf", {31'd0, rd[3]}, 32'd1);
    check("irq_udf", {31'd0, irq}, 32'd1);
    ref_xfer(1'b1, 8'h08, 32'h8, rd, er);
    ref_xfer(1'b0, 8'h08, 32'd0, rd, er);
    check("status_udf_clr", {31'd0, rd[3]}, 32'd0);
    check("irq_clr", {31'd0, irq}, 32'd0);

    // RX interrupt enable: irq follows Empty with one cycle latency
    ref_xfer(1'b1, 8'h10, 32'h1, rd, er);
    @(negedge clk);
    rx_fifo_Empty = 1'b0;
    #1;
    check("irq_before_edge", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_after_edge", {31'd0, irq}, 32'd1);

    // reset during POP aborts the transfer
    ref_xfer(1'b1, 8'h0C, 32'h123, rd, er);
    rx_next_byte = 8'h77;
    pop_snap = pop_cnt;
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h04;
    @(negedge clk);
    PENABLE = 1'b1;
    #1;
    check("pop_strobe", {31'd0, rx_fifo_readEn}, 32'd1);
    check("pop_wait", {31'd0, PREADY}, 32'd0);
    reset = 1'b1;
    #1;
    check("abort_re", {31'd0, rx_fifo_readEn}, 32'd0);
    check("abort_irq", {31'd0, irq}, 32'd0);
    check("abort_baud", {21'd0, baud_final_value}, 32'd650);
    check("abort_pready", {31'd0, PREADY}, 32'd1);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("abort_no_pop", pop_cnt - pop_snap, 32'd0);
    check("abort_txdata", {24'd0, tx_fifo_dataIn}, 32'd0);

    // random traffic against the model
    for (int i = 0; i < 60; i++) begin
      logic [7:0]  a;
      logic [31:0] wd;
      logic        wr;
      int          sel;
      tx_fifo_Full  = 1'($urandom_range(0, 1));
      rx_fifo_Empty = 1'($urandom_range(0, 1));
      rx_next_byte  = 8'($urandom);
      wd  = $urandom;
      wr  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 6);
      if (sel <= 4) a = 8'(sel * 4) | 8'($urandom_range(0, 3));
      else if (sel == 5) a = 8'h14 | 8'($urandom_range(0, 3));
      else a = 8'hF0 | 8'($urandom_range(0, 15));
      ref_xfer(wr, a, wd, rd, er);
    end

    check("no_back_to_back", {31'd0, b2b_err}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
